// File: rtl/eth_pkg.sv
// Shared definitions for the 64b/66b PCS receive path.
// Sync-header encodings and the block-lock FSM state type.
package eth_pkg;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    typedef enum logic {
        TEST_SH,
        SLIP_WAIT
    } blk_lock_state_t;

endpackage

// File: rtl/eth_block_lock.sv
// 64b/66b block-lock stage: checks sync headers, requests gearbox slips until aligned,
// and registers the beat through to the descrambler with one cycle of latency.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// TEST_SH   | counting headers in the current window, deciding lock/slip
// SLIP_WAIT | slip issued; headers ignored while the GT realigns
module eth_block_lock
    import eth_pkg::*;
#(
    parameter int DATA_WIDTH       = 16,
    parameter int GOOD_SH_COUNT    = 64,
    parameter int BAD_SH_LIMIT     = 16,
    parameter int SLIP_WAIT_CYCLES = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_data_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [1:0]            i_header,
    input  logic                  i_headervalid,
    output logic                  o_data_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [1:0]            o_header,
    output logic                  o_headervalid,
    output logic                  o_rx_slip,
    output logic                  o_block_lock
);

    localparam int CNT_W  = $clog2(GOOD_SH_COUNT + 1);
    localparam int BAD_W  = $clog2(BAD_SH_LIMIT + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT_CYCLES + 1);

    blk_lock_state_t    state;
    logic [CNT_W-1:0]   sh_cnt;
    logic [CNT_W-1:0]   cnt_n;
    logic [BAD_W-1:0]   sh_bad_cnt;
    logic [BAD_W-1:0]   bad_n;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               hev;
    logic               shv;

    assign hev = i_data_valid & i_headervalid & (state == TEST_SH);
    assign shv = (i_header == SH_DATA) | (i_header == SH_CTRL);

    always_comb begin
        cnt_n = sh_cnt + CNT_W'(1);
        bad_n = sh_bad_cnt;
        if (!shv && (sh_bad_cnt != BAD_W'(BAD_SH_LIMIT)))
            bad_n = sh_bad_cnt + BAD_W'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data_valid  <= 1'b0;
            o_data        <= '0;
            o_header      <= 2'b00;
            o_headervalid <= 1'b0;
        end else begin
            o_data_valid  <= i_data_valid;
            o_data        <= i_data;
            o_header      <= i_header;
            o_headervalid <= i_headervalid & i_data_valid;
        end
    end

    // wait_cnt is a down-counter; SLIP_WAIT lasts exactly SLIP_WAIT_CYCLES cycles
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= TEST_SH;
            sh_cnt       <= '0;
            sh_bad_cnt   <= '0;
            wait_cnt     <= '0;
            o_rx_slip    <= 1'b0;
            o_block_lock <= 1'b0;
        end else begin
            o_rx_slip <= 1'b0;
            case (state)
                TEST_SH: begin
                    if (hev) begin
                        sh_cnt     <= cnt_n;
                        sh_bad_cnt <= bad_n;
                        if ((!o_block_lock && !shv) ||
                            (o_block_lock && (bad_n == BAD_W'(BAD_SH_LIMIT)))) begin
                            o_block_lock <= 1'b0;
                            o_rx_slip    <= 1'b1;
                            state        <= SLIP_WAIT;
                            wait_cnt     <= WAIT_W'(SLIP_WAIT_CYCLES - 1);
                            sh_cnt       <= '0;
                            sh_bad_cnt   <= '0;
                        end else if (cnt_n == CNT_W'(GOOD_SH_COUNT)) begin
                            if (bad_n == '0)
                                o_block_lock <= 1'b1;
                            sh_cnt     <= '0;
                            sh_bad_cnt <= '0;
                        end
                    end
                end
                SLIP_WAIT: begin
                    if (wait_cnt == '0)
                        state <= TEST_SH;
                    else
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_block_lock.sv
// Randomized bench for eth_block_lock against a window/slip reference model.
// Every cycle compares all outputs; directed phases cover lock, slip, loss and reset.
module tb_eth_block_lock;

    localparam int DW   = 16;
    localparam int GOOD = 64;
    localparam int BADL = 16;
    localparam int SW   = 32;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_data_valid = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic [1:0]    i_header = 2'b00;
    logic          i_headervalid = 1'b0;
    logic          o_data_valid;
    logic [DW-1:0] o_data;
    logic [1:0]    o_header;
    logic          o_headervalid;
    logic          o_rx_slip;
    logic          o_block_lock;

    eth_block_lock #(
        .DATA_WIDTH(DW), .GOOD_SH_COUNT(GOOD), .BAD_SH_LIMIT(BADL), .SLIP_WAIT_CYCLES(SW)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_data_valid(i_data_valid), .i_data(i_data),
        .i_header(i_header), .i_headervalid(i_headervalid),
        .o_data_valid(o_data_valid), .o_data(o_data),
        .o_header(o_header), .o_headervalid(o_headervalid),
        .o_rx_slip(o_rx_slip), .o_block_lock(o_block_lock)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_slip = -1;
    int n_slips  = 0;

    // reference model: window counts, wait budget and expected registered outputs
    int            m_cnt, m_bad, m_wait;
    bit            m_lock, m_slip, m_dv, m_hv;
    logic [1:0]    m_hdr;
    logic [DW-1:0] m_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [1:0] good_hdr();
        return ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [1:0] bad_hdr();
        return ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_bad = 0; m_wait = 0;
        m_lock = 0; m_slip = 0; m_dv = 0; m_hv = 0;
        m_hdr = 2'b00; m_data = '0;
        last_slip = -1;
    endtask

    task automatic model_edge(input bit dv, input bit hv, input logic [1:0] hdr,
                              input logic [DW-1:0] d);
        bit ok;
        m_data = d; m_dv = dv; m_hdr = hdr; m_hv = dv & hv; m_slip = 0;
        ok = (hdr == 2'b01) || (hdr == 2'b10);
        if (m_wait > 0) begin
            m_wait--;
        end else if (dv && hv) begin
            m_cnt++;
            if (!ok && m_bad < BADL) m_bad++;
            if ((!m_lock && !ok) || (m_lock && m_bad == BADL)) begin
                m_lock = 0; m_slip = 1; m_wait = SW; m_cnt = 0; m_bad = 0;
            end else if (m_cnt == GOOD) begin
                if (m_bad == 0) m_lock = 1;
                m_cnt = 0; m_bad = 0;
            end
        end
    endtask

    task automatic step(input bit dv, input bit hv, input logic [1:0] hdr);
        logic [DW-1:0] d;
        d = DW'($urandom);
        @(negedge i_clk);
        i_data_valid = dv; i_headervalid = hv; i_header = hdr; i_data = d;
        @(posedge i_clk);
        model_edge(dv, hv, hdr, d);
        cyc++;
        #1;
        chk("data", 32'(o_data), 32'(m_data));
        chk("data_valid", 32'(o_data_valid), 32'(m_dv));
        chk("header", 32'(o_header), 32'(m_hdr));
        chk("headervalid", 32'(o_headervalid), 32'(m_hv));
        chk("rx_slip", 32'(o_rx_slip), 32'(m_slip));
        chk("block_lock", 32'(o_block_lock), 32'(m_lock));
        if (o_rx_slip) begin
            if (last_slip >= 0)
                chk("slip_gap_ok", 32'(cyc - last_slip >= SW + 1), 32'd1);
            last_slip = cyc;
            n_slips++;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_data"}, 32'(o_data), 32'd0);
        chk({tag, "_dv"}, 32'(o_data_valid), 32'd0);
        chk({tag, "_hdr"}, 32'(o_header), 32'd0);
        chk({tag, "_hv"}, 32'(o_headervalid), 32'd0);
        chk({tag, "_slip"}, 32'(o_rx_slip), 32'd0);
        chk({tag, "_lock"}, 32'(o_block_lock), 32'd0);
    endtask

    task automatic async_reset(input string tag);
        @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1 check_outputs_zero(tag);
        model_reset();
        i_data_valid = 0; i_headervalid = 0; i_header = 2'b00; i_data = '0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic good_run(input int n);
        for (int i = 0; i < n; i++) step(1, 1, good_hdr());
    endtask

    initial begin
        bit flags [GOOD];
        int s0, k, off, q, picked, idx;

        model_reset();
        #1 check_outputs_zero("reset");
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // 1) clean lock from reset
        s0 = n_slips;
        good_run(GOOD - 1);
        chk("t1_lock_before_64", 32'(o_block_lock), 32'd0);
        good_run(1);
        chk("t1_lock_after_64", 32'(o_block_lock), 32'd1);
        chk("t1_no_slip", 32'(n_slips - s0), 32'd0);

        // 2) unlocked invalid header on beat 5
        async_reset("t2_rst");
        good_run(4);
        step(1, 1, 2'b00);
        chk("t2_slip_pulse", 32'(o_rx_slip), 32'd1);
        step(1, 1, bad_hdr());
        chk("t2_slip_one_cycle", 32'(o_rx_slip), 32'd0);
        for (int i = 0; i < SW - 1; i++) step(1, 1, bad_hdr());
        good_run(GOOD);
        chk("t2_relock", 32'(o_block_lock), 32'd1);

        // 3) locked: 15 bad in a window holds lock, 16 bad drops it
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < GOOD; i++) flags[i] = 0;
            picked = 0;
            while (picked < BADL - 1 + pass) begin
                idx = $urandom_range(0, GOOD - 1);
                if (!flags[idx]) begin flags[idx] = 1; picked++; end
            end
            s0 = n_slips;
            for (int i = 0; i < GOOD && m_lock; i++)
                step(1, 1, flags[i] ? bad_hdr() : good_hdr());
            if (pass == 0) begin
                chk("t3_lock_held_15", 32'(o_block_lock), 32'd1);
                chk("t3_no_slip_15", 32'(n_slips - s0), 32'd0);
            end else begin
                chk("t3_lock_lost_16", 32'(o_block_lock), 32'd0);
                chk("t3_slip_16", 32'(n_slips - s0), 32'd1);
            end
        end

        // 4) gearbox misaligned by k bits
        async_reset("t4_rst");
        k = $urandom_range(1, 5);
        off = k;
        s0 = n_slips;
        for (int i = 0; i < 2000 && !o_block_lock; i++) begin
            step(1, 1, (off == 0) ? good_hdr() : bad_hdr());
            if (o_rx_slip && off > 0) off--;
        end
        chk("t4_lock", 32'(o_block_lock), 32'd1);
        chk("t4_slips_eq_k", 32'(n_slips - s0), 32'(k));

        // 5) valid / headervalid gaps
        async_reset("t5_rst");
        q = 0;
        for (int i = 0; i < 3000 && !o_block_lock; i++) begin
            bit dv, hv;
            dv = ($urandom_range(0, 3) != 0);
            hv = ($urandom_range(0, 2) != 0);
            if (dv && hv) q++;
            step(dv, hv, good_hdr());
        end
        chk("t5_lock", 32'(o_block_lock), 32'd1);
        chk("t5_qualified_64", 32'(q), 32'(GOOD));

        // 6) reset while locked, then during SLIP_WAIT
        async_reset("t6_locked_rst");
        good_run(GOOD);
        chk("t6_relock", 32'(o_block_lock), 32'd1);
        async_reset("t6_lock_drop");
        good_run(2);
        step(1, 1, bad_hdr());
        chk("t6_slip", 32'(o_rx_slip), 32'd1);
        for (int i = 0; i < 5; i++) step(1, 1, good_hdr());
        async_reset("t6_wait_rst");
        good_run(GOOD);
        chk("t6_clean_relock", 32'(o_block_lock), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
